// File: rtl/board_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : board_ram_arbiter
// Brief    : Round-robin, hold-while-requested owner arbitration for the
//            single-port board RAM, with a one-cycle handover gap.
// Revision : 1.0 - initial release
// ============================================================================
module board_ram_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 6,
  parameter int MAX_HOLD = 0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_wren,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      ram_wren,
  input  logic [DATA_W-1:0]         ram_Q,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy,
  output logic                      timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HC_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    HANDOVER = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    gidx, gidx_nxt, rr_ptr, rr_ptr_nxt, pick, gidx_p1;
  logic                pick_vld, hold_hit;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                wren_nxt, timeout_nxt;
  logic [HC_W-1:0]     hold_cnt, hold_cnt_nxt;

  assign rd_data = ram_Q;
  assign busy    = (state != IDLE);
  assign gidx_p1 = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD - 1));

  // Scan downwards so the last match, i.e. the one closest to rr_ptr, wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[IDX_W'(idx)]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    gidx_nxt     = gidx;
    rr_ptr_nxt   = rr_ptr;
    addr_nxt     = ram_addr;
    data_nxt     = ram_data;
    wren_nxt     = 1'b0;
    timeout_nxt  = 1'b0;
    hold_cnt_nxt = hold_cnt;
    case (state)
      GRANT: begin
        addr_nxt = req_addr[gidx*ADDR_W +: ADDR_W];
        data_nxt = req_data[gidx*DATA_W +: DATA_W];
        if (!req[gidx] || hold_hit) begin
          gnt_nxt     = '0;
          rr_ptr_nxt  = gidx_p1;
          state_nxt   = HANDOVER;
          timeout_nxt = req[gidx] && hold_hit;
        end else begin
          wren_nxt = req_wren[gidx];
          if (hold_cnt != '1) hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        // IDLE and HANDOVER arbitrate identically; HANDOVER is the enforced gap.
        if (pick_vld) begin
          gnt_nxt       = '0;
          gnt_nxt[pick] = 1'b1;
          gidx_nxt      = pick;
          hold_cnt_nxt  = '0;
          state_nxt     = GRANT;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      gnt      <= '0;
      gidx     <= '0;
      rr_ptr   <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gidx     <= gidx_nxt;
      rr_ptr   <= rr_ptr_nxt;
      ram_addr <= addr_nxt;
      ram_data <= data_nxt;
      ram_wren <= wren_nxt;
      timeout  <= timeout_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_ram_arbiter
// Brief    : Scoreboard bench for board_ram_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_ram_arbiter;

  logic        clk;
  logic        resetn;
  logic [2:0]  req, wren, gnt;
  logic [7:0]  addr_a [3];
  logic [5:0]  data_a [3];
  logic [23:0] req_addr;
  logic [17:0] req_data;
  logic [7:0]  ram_addr;
  logic [5:0]  ram_data, ram_q, rd_data;
  logic        ram_wren, busy, timeout;
  logic [5:0]  mem [256];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] g;
    int         gap;
  } gexp_t;

  gexp_t       gq[$];
  logic [13:0] wq[$];
  gexp_t       e_m;
  logic [13:0] w_m;
  logic [2:0]  prev_gnt;
  int          gap;
  int          cnt [3];
  int          left [3];

  assign req_addr = {addr_a[2], addr_a[1], addr_a[0]};
  assign req_data = {data_a[2], data_a[1], data_a[0]};

  board_ram_arbiter #(
    .NUM_REQ (3),
    .ADDR_W  (8),
    .DATA_W  (6),
    .MAX_HOLD(16)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_wren(wren),
    .gnt     (gnt),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_wren(ram_wren),
    .ram_Q   (ram_q),
    .rd_data (rd_data),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_g(input logic [2:0] g, input int gp);
    gexp_t e;
    e.g   = g;
    e.gap = gp;
    gq.push_back(e);
  endtask

  task automatic push_w(input int i, input int n);
    repeat (n) wq.push_back({addr_a[i], data_a[i]});
  endtask

  // Each requester drops req after holding the grant `hold` cycles and
  // re-requests on the following cycle while it still has grants left.
  task automatic run_agents(input int hold, input int late_idx, input int late_cyc,
                            input int max_cyc);
    int c;
    c = 0;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    while (c < max_cyc) begin
      @(negedge clk);
      if (late_idx >= 0 && c == late_cyc) req[late_idx] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (gnt[i]) begin
          cnt[i]++;
          if (cnt[i] == hold) req[i] = 1'b0;
        end else if (!req[i] && cnt[i] >= hold && left[i] > 0) begin
          req[i] = 1'b1;
          left[i]--;
          cnt[i] = 0;
        end
      end
      c++;
      if (req == 3'b000 && gnt == 3'b000) break;
    end
    if (c >= max_cyc) note_fail("agent_cycle_budget", 32'(c));
  endtask

  // Monitor: pops the scoreboard on each new grant and each RAM write.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_gnt = 3'b000;
      gap      = 0;
    end else begin
      chk("gnt_onehot", 32'((gnt & (gnt - 3'd1)) == 3'd0), 32'd1);
      if (gnt != 3'b000 && prev_gnt == 3'b000) begin
        if (gq.size() == 0) note_fail("grant_unexpected", 32'(gnt));
        else begin
          e_m = gq.pop_front();
          chk("grant_owner", 32'(gnt), 32'(e_m.g));
          if (e_m.gap >= 0) chk("handover_gap", 32'(gap), 32'(e_m.gap));
        end
      end
      if (gnt == 3'b000 && prev_gnt != 3'b000) chk("gap_wren", 32'(ram_wren), 32'd0);
      if (ram_wren) begin
        if (wq.size() == 0) note_fail("write_unexpected", 32'({ram_addr, ram_data}));
        else begin
          w_m = wq.pop_front();
          chk("ram_write", 32'({ram_addr, ram_data}), 32'(w_m));
        end
      end
      gap      = (gnt == 3'b000) ? gap + 1 : 0;
      prev_gnt = gnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 6'd0;
    mem[10] = 6'd5;
    ram_q   = 6'd0;
    resetn  = 1'b0;
    req     = 3'b000;
    wren    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr_a[i] = 8'd0;
      data_a[i] = 6'd0;
    end
    cyc(3);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_addr", 32'(ram_addr), 32'd0);
    chk("reset_data", 32'(ram_data), 32'd0);
    chk("reset_wren", 32'(ram_wren), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    cyc(2);

    // Single requester write
    addr_a[1] = 8'd57; data_a[1] = 6'd3; wren = 3'b010;
    push_g(3'b010, -1); push_w(1, 1);
    req = 3'b010;
    cyc(1);
    chk("single_gnt", 32'(gnt), 32'(3'b010));
    chk("single_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("single_addr", 32'(ram_addr), 32'd57);
    chk("single_wren", 32'(ram_wren), 32'd1);
    req = 3'b000;
    cyc(4);

    // Request dropped in its grant cycle: one-cycle grant, no write
    addr_a[2] = 8'd20; data_a[2] = 6'd7; wren = 3'b100;
    push_g(3'b100, -1);
    req = 3'b100;
    cyc(1);
    chk("drop_gnt", 32'(gnt), 32'(3'b100));
    req = 3'b000;
    cyc(1);
    chk("drop_gnt_cleared", 32'(gnt), 32'd0);
    chk("drop_no_write", 32'(ram_wren), 32'd0);
    cyc(3);

    // Read path
    addr_a[2] = 8'd10; wren = 3'b000;
    push_g(3'b100, -1);
    req = 3'b100;
    cyc(2);
    chk("read_addr", 32'(ram_addr), 32'd10);
    cyc(1);
    chk("read_data", 32'(rd_data), 32'd5);
    req = 3'b000;
    cyc(4);

    // Contention: order 0,1,2,0 with single-cycle gaps
    addr_a[0] = 8'd1; data_a[0] = 6'd11;
    addr_a[1] = 8'd2; data_a[1] = 6'd22;
    addr_a[2] = 8'd3; data_a[2] = 6'd33;
    wren = 3'b111;
    push_g(3'b001, -1); push_g(3'b010, 1); push_g(3'b100, 1); push_g(3'b001, 1);
    push_w(0, 3); push_w(1, 3); push_w(2, 3); push_w(0, 3);
    left[0] = 1; left[1] = 0; left[2] = 0;
    req = 3'b111;
    run_agents(4, -1, 0, 60);
    cyc(3);

    // Fairness: 0 re-requests at once but 2 must go first
    addr_a[0] = 8'd4; data_a[0] = 6'd12;
    addr_a[2] = 8'd6; data_a[2] = 6'd14;
    wren = 3'b101;
    push_g(3'b001, -1); push_g(3'b100, 1); push_g(3'b001, 1);
    push_w(0, 3); push_w(2, 3); push_w(0, 3);
    left[0] = 1; left[1] = 0; left[2] = 0;
    req = 3'b001;
    run_agents(4, 2, 1, 60);
    cyc(3);

    // Timeout: requester 0 stuck, revoked after 16 cycles, then 1 granted
    wren = 3'b000;
    push_g(3'b001, -1); push_g(3'b010, 1);
    req = 3'b001;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) req[1] = 1'b1;
      if (gnt == 3'b001) n++;
      else break;
    end
    chk("timeout_hold_cycles", 32'(n), 32'd16);
    chk("timeout_pulse", 32'(timeout), 32'd1);
    cyc(1);
    chk("timeout_pulse_end", 32'(timeout), 32'd0);
    chk("timeout_next_owner", 32'(gnt), 32'(3'b010));
    req = 3'b000;
    cyc(4);

    // Reset in the middle of a write
    addr_a[1] = 8'd33; data_a[1] = 6'd9; wren = 3'b010;
    push_g(3'b010, -1); push_w(1, 1);
    req = 3'b010;
    cyc(2);
    chk("pre_reset_wren", 32'(ram_wren), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_wren", 32'(ram_wren), 32'd0);
    chk("async_reset_gnt", 32'(gnt), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    req = 3'b000;
    @(negedge clk);
    #1 resetn = 1'b1;
    cyc(2);

    // After reset the pointer restarts at 0, so 1 beats 2
    wren = 3'b000;
    push_g(3'b010, -1);
    req = 3'b110;
    cyc(1);
    req = 3'b000;
    cyc(4);

    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("write_queue_empty", 32'(wq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
